// File: rtl/tortoise_pkg.sv
// Shared fetch/decode types and front-end sizing constants for the tortoise core.
package tortoise_pkg;

  localparam int INSTR_PER_FETCH = 2;
  localparam int INSTR_PER_ISSUE = 2;
  localparam int IFQ_SLOTS       = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/instr_compact.sv
// Lane-mask compaction: per-lane write offset (exclusive prefix popcount) and total enabled lanes.
module instr_compact #(
  parameter  int LANES = 2,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] mask,
  output logic [CW-1:0]    offset [LANES],
  output logic [CW-1:0]    total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      offset[l] = acc;
      acc       = acc + CW'(mask[l]);
    end
    total = acc;
  end

endmodule

// File: rtl/instr_slot_queue.sv
// Per-instruction fetch queue: compacts masked fetch rows into a circular slot buffer
// and presents the oldest ISSUE_WIDTH entries to decode.
module instr_slot_queue
  import tortoise_pkg::*;
#(
  parameter int INSTR_PER_ROW = INSTR_PER_FETCH,
  parameter int ISSUE_WIDTH   = INSTR_PER_ISSUE,
  parameter int DEPTH         = IFQ_SLOTS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [INSTR_PER_ROW-1:0]       mask_i,
  input  fetch_entry_t                   instr_i [INSTR_PER_ROW],
  output logic [ISSUE_WIDTH-1:0]         valid_o,
  output fetch_entry_t                   instr_o [ISSUE_WIDTH],
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]     usage_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CCW = $clog2(INSTR_PER_ROW + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM_C  = CW'(DEPTH - INSTR_PER_ROW);
  localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_WIDTH);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;

  logic [CCW-1:0] lane_off [INSTR_PER_ROW];
  logic [CCW-1:0] push_total;
  logic           push_en;
  logic [CW-1:0]  push_cnt, pop_req, pop_eff, avail;

  instr_compact #(.LANES(INSTR_PER_ROW)) u_compact (
    .mask   (mask_i),
    .offset (lane_off),
    .total  (push_total)
  );

  assign ready_o  = (count <= ROOM_C);
  assign push_en  = valid_i && ready_o && !flush_i;
  assign push_cnt = push_en ? CW'(push_total) : '0;

  // Decode may only retire what is both present and presented; excess is clamped.
  assign avail   = (count > ISSUE_C) ? ISSUE_C : count;
  assign pop_req = CW'(pop_cnt_i);
  assign pop_eff = (pop_req > avail) ? avail : pop_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PW'(pop_eff);
      wptr  <= wptr + PW'(push_cnt);
      count <= count + push_cnt - pop_eff;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int l = 0; l < INSTR_PER_ROW; l++) begin
        if (mask_i[l]) slots[wptr + PW'(lane_off[l])] <= instr_i[l];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      valid_o[k] = (count > CW'(k));
      instr_o[k] = slots[rptr + PW'(k)];
    end
  end

  assign usage_o = count;

  a_pop_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_req <= avail);
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= DEPTH_C);
  a_ptr_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count == DEPTH_C) ? (wptr == rptr) : (PW'(count) == PW'(wptr - rptr)));

endmodule

// File: tb/tb_instr_slot_queue.sv
// Directed bench for instr_slot_queue with DEPTH=8, INSTR_PER_ROW=2, ISSUE_WIDTH=2.
module tb_instr_slot_queue;
  import tortoise_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [1:0]   mask_i = 2'b00;
  fetch_entry_t instr_i [2];
  logic [1:0]   valid_o;
  fetch_entry_t instr_o [2];
  logic [1:0]   pop_cnt_i = 2'd0;
  logic [3:0]   usage_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       vld;
    logic [1:0] mask;
    int         a, b;
    logic [1:0] pop;
    logic       rdy;
    logic [1:0] v;
    logic [3:0] usg;
    int         e0, e1;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];
  fetch_entry_t q [$];

  always #5 clk_i = ~clk_i;

  instr_slot_queue #(.INSTR_PER_ROW(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .mask_i    (mask_i),
    .instr_i   (instr_i),
    .valid_o   (valid_o),
    .instr_o   (instr_o),
    .pop_cnt_i (pop_cnt_i),
    .usage_o   (usage_o)
  );

  function automatic fetch_entry_t ent(int id);
    fetch_entry_t e;
    e.pc   = 32'(id * 4);
    e.insn = 32'hC0DE_0000 | 32'(id);
    return e;
  endfunction

  function automatic vec_t mkv(logic vld, logic [1:0] mask, int a, int b, logic [1:0] pop,
                               logic rdy, logic [1:0] v, logic [3:0] usg, int e0, int e1);
    vec_t t;
    t.vld = vld; t.mask = mask; t.a = a; t.b = b; t.pop = pop;
    t.rdy = rdy; t.v = v; t.usg = usg; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(logic vld, logic [1:0] mask, int a, int b, logic [1:0] pop, logic fl);
    valid_i    = vld;
    mask_i     = mask;
    instr_i[0] = ent(a);
    instr_i[1] = ent(b);
    pop_cnt_i  = pop;
    flush_i    = fl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int id;
    tbl[0]  = mkv(1, 2'b11,  1,  2, 2'd0, 1, 2'b11, 4'd2,  1,  2);
    tbl[1]  = mkv(0, 2'b00,  0,  0, 2'd2, 1, 2'b00, 4'd0,  0,  0);
    tbl[2]  = mkv(1, 2'b10,  3,  4, 2'd0, 1, 2'b01, 4'd1,  4,  0);
    tbl[3]  = mkv(1, 2'b01,  5,  6, 2'd0, 1, 2'b11, 4'd2,  4,  5);
    tbl[4]  = mkv(0, 2'b00,  0,  0, 2'd1, 1, 2'b01, 4'd1,  5,  0);
    tbl[5]  = mkv(0, 2'b00,  0,  0, 2'd1, 1, 2'b00, 4'd0,  0,  0);
    tbl[6]  = mkv(1, 2'b11,  7,  8, 2'd0, 1, 2'b11, 4'd2,  7,  8);
    tbl[7]  = mkv(1, 2'b11,  9, 10, 2'd0, 1, 2'b11, 4'd4,  7,  8);
    tbl[8]  = mkv(1, 2'b11, 11, 12, 2'd0, 1, 2'b11, 4'd6,  7,  8);
    tbl[9]  = mkv(1, 2'b11, 13, 14, 2'd0, 0, 2'b11, 4'd8,  7,  8);
    tbl[10] = mkv(1, 2'b11, 15, 16, 2'd0, 0, 2'b11, 4'd8,  7,  8);
    tbl[11] = mkv(1, 2'b11, 15, 16, 2'd2, 1, 2'b11, 4'd6,  9, 10);
    tbl[12] = mkv(1, 2'b11, 15, 16, 2'd0, 0, 2'b11, 4'd8,  9, 10);
    tbl[13] = mkv(0, 2'b00,  0,  0, 2'd2, 1, 2'b11, 4'd6, 11, 12);
    tbl[14] = mkv(0, 2'b00,  0,  0, 2'd2, 1, 2'b11, 4'd4, 13, 14);
    tbl[15] = mkv(0, 2'b00,  0,  0, 2'd2, 1, 2'b11, 4'd2, 15, 16);
    tbl[16] = mkv(0, 2'b00,  0,  0, 2'd2, 1, 2'b00, 4'd0,  0,  0);
    tbl[17] = mkv(1, 2'b00, 20, 21, 2'd0, 1, 2'b00, 4'd0,  0,  0);

    drive(0, 2'b00, 0, 0, 2'd0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_usage", 64'(usage_o), 64'd0);
    chk("reset_no_x", 64'($isunknown({ready_o, valid_o, usage_o})), 64'd0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].vld, tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].pop, 0);
      step();
      chk($sformatf("v%0d_ready", i), 64'(ready_o), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_valid", i), 64'(valid_o), 64'(tbl[i].v));
      chk($sformatf("v%0d_usage", i), 64'(usage_o), 64'(tbl[i].usg));
      if (tbl[i].v[0]) chk($sformatf("v%0d_instr0", i), instr_o[0], ent(tbl[i].e0));
      if (tbl[i].v[1]) chk($sformatf("v%0d_instr1", i), instr_o[1], ent(tbl[i].e1));
    end

    // Streaming across pointer wrap with simultaneous push and pop.
    id = 100;
    repeat (2) begin
      drive(1, 2'b11, id, id + 1, 2'd0, 0);
      q.push_back(ent(id));
      q.push_back(ent(id + 1));
      id += 2;
      step();
    end
    chk("stream_preload_usage", 64'(usage_o), 64'd4);
    for (int c = 0; c < 12; c++) begin
      drive(1, 2'b11, id, id + 1, 2'd2, 0);
      step();
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(ent(id));
      q.push_back(ent(id + 1));
      id += 2;
      chk($sformatf("stream%0d_usage", c), 64'(usage_o), 64'd4);
      chk($sformatf("stream%0d_instr0", c), instr_o[0], q[0]);
      chk($sformatf("stream%0d_instr1", c), instr_o[1], q[1]);
    end

    // Flush wins over a same-cycle push and pop.
    drive(1, 2'b01, id, id + 1, 2'd0, 0);
    step();
    chk("preflush_usage", 64'(usage_o), 64'd5);
    drive(1, 2'b11, 150, 151, 2'd2, 1);
    #1;
    chk("flush_cycle_valid", 64'(valid_o), 64'b11);
    chk("flush_cycle_usage", 64'(usage_o), 64'd5);
    step();
    drive(0, 2'b00, 0, 0, 2'd0, 0);
    chk("postflush_usage", 64'(usage_o), 64'd0);
    chk("postflush_valid", 64'(valid_o), 64'd0);
    chk("postflush_ready", 64'(ready_o), 64'd1);
    drive(1, 2'b11, 200, 201, 2'd0, 0);
    step();
    drive(0, 2'b00, 0, 0, 2'd0, 0);
    chk("refill_usage", 64'(usage_o), 64'd2);
    chk("refill_instr0", instr_o[0], ent(200));
    chk("refill_instr1", instr_o[1], ent(201));

    // Asynchronous reset clears state between clock edges.
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_usage", 64'(usage_o), 64'd0);
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd1);
    #2 rst_ni = 1'b1;
    step();
    chk("after_rst_usage", 64'(usage_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
